// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Raster timing generator for the HDMI pipeline. It synchronizes and
//   qualifies the PLL lock, then produces registered DE/HSYNC/VSYNC, the
//   active pixel coordinates and a frame-start strobe. All timing outputs
//   stay idle while the lock is absent or not yet qualified.
//
// Ports:
//   I_pxl_clk      pixel clock, sole clock
//   I_rst_n        asynchronous active-low reset
//   I_pll_lock     PLL lock, asynchronous to I_pxl_clk
//   O_de           data enable, high in the active region
//   O_hs / O_vs    syncs, active level set by HS_POL / VS_POL
//   O_x / O_y      active pixel column / line, 0 outside the active region
//   O_frame_start  one-cycle pulse with the first active pixel
//   O_running      high while timing is running
module video_timing_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int LOCK_WAIT = 1024
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_pll_lock,
    output logic        O_de,
    output logic        O_hs,
    output logic        O_vs,
    output logic [11:0] O_x,
    output logic [10:0] O_y,
    output logic        O_frame_start,
    output logic        O_running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    localparam int              LW_W      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LW_W-1:0] LOCK_LAST = LW_W'(LOCK_WAIT - 1);

    typedef enum logic {WAIT_LOCK, RUN} state_t;

    state_t          state;
    logic [LW_W-1:0] lock_cnt;
    logic [11:0]     h_cnt;
    logic [10:0]     v_cnt;
    logic            lock_meta, lock_s;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= I_pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Region decode of the current counter state; registered below.
    logic h_act, v_act, active, hs_act, vs_act, h_wrap, v_wrap;
    assign h_act  = (h_cnt < H_ACT_END);
    assign v_act  = (v_cnt < V_ACT_END);
    assign active = h_act && v_act;
    assign hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state         <= WAIT_LOCK;
            lock_cnt      <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            O_de          <= 1'b0;
            O_hs          <= ~HS_ON;
            O_vs          <= ~VS_ON;
            O_x           <= '0;
            O_y           <= '0;
            O_frame_start <= 1'b0;
            O_running     <= 1'b0;
        end else if (state == WAIT_LOCK) begin
            // Outputs are already idle here: reset or the RUN exit set them.
            h_cnt <= '0;
            v_cnt <= '0;
            if (!lock_s) begin
                lock_cnt <= '0;
            end else if (lock_cnt == LOCK_LAST) begin
                state     <= RUN;
                lock_cnt  <= '0;
                O_running <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end else begin
            if (!lock_s) begin
                // Lost lock: drop straight back to the idle output state.
                state         <= WAIT_LOCK;
                lock_cnt      <= '0;
                h_cnt         <= '0;
                v_cnt         <= '0;
                O_de          <= 1'b0;
                O_hs          <= ~HS_ON;
                O_vs          <= ~VS_ON;
                O_x           <= '0;
                O_y           <= '0;
                O_frame_start <= 1'b0;
                O_running     <= 1'b0;
            end else begin
                O_de          <= active;
                O_hs          <= hs_act ? HS_ON : ~HS_ON;
                O_vs          <= vs_act ? VS_ON : ~VS_ON;
                O_x           <= active ? h_cnt : 12'd0;
                O_y           <= active ? v_cnt : 11'd0;
                O_frame_start <= (h_cnt == 12'd0) && (v_cnt == 11'd0);
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? 11'd0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int LW = 4;
    localparam int HT = HA + HF + HSW + HB;   // 14
    localparam int VT = VA + VF + VSW + VB;   // 7
    localparam bit HSP = 1'b1, VSP = 1'b1;

    logic clk = 1'b0, rst_n = 1'b0, lock = 1'b0, lock2 = 1'b0;
    always #5 clk = ~clk;

    logic        de, hs, vs, fs, run;
    logic [11:0] x;
    logic [10:0] y;
    logic        de2, hs2, vs2, fs2, run2;
    logic [11:0] x2;
    logic [10:0] y2;

    int errors = 0;
    int checks = 0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1), .VS_POL(1), .LOCK_WAIT(LW)
    ) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock),
        .O_de(de), .O_hs(hs), .O_vs(vs), .O_x(x), .O_y(y),
        .O_frame_start(fs), .O_running(run)
    );

    video_timing_gen dut_1080 (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_pll_lock(lock2),
        .O_de(de2), .O_hs(hs2), .O_vs(vs2), .O_x(x2), .O_y(y2),
        .O_frame_start(fs2), .O_running(run2)
    );

    // {de, hs, vs, x[11:0], y[10:0], frame_start, running}
    function automatic logic [27:0] pack(bit d, bit h, bit v, int px, int py, bit f, bit r);
        return {d, h, v, 12'(px), 11'(py), f, r};
    endfunction

    localparam logic [27:0] IDLE = {1'b0, !HSP, !VSP, 12'd0, 11'd0, 1'b0, 1'b0};

    wire [27:0] dut_vec = {de, hs, vs, x, y, fs, run};
    wire [27:0] big_vec = {de2, hs2, vs2, x2, y2, fs2, run2};

    // Reference model: lock seen two edges late; RUN starts once LW
    // consecutive synced-high samples are seen; raster position is the
    // elapsed RUN time t, decoded with div/mod.
    typedef struct {
        bit          h1, h2, rn;
        int          streak, t;
        logic [27:0] outv;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t mstep(mstate_t s, bit lk);
        mstate_t n = s;
        bit l2 = s.h2;
        int h, v;
        bit act, hsa, vsa;
        n.h2 = s.h1;
        n.h1 = lk;
        n.streak = l2 ? s.streak + 1 : 0;
        if (!s.rn) begin
            n.outv = IDLE;
            if (l2 && n.streak >= LW) begin
                n.rn = 1'b1;
                n.t = 0;
                n.outv = pack(0, !HSP, !VSP, 0, 0, 0, 1);
            end
        end else if (!l2) begin
            n.rn = 1'b0;
            n.outv = IDLE;
        end else begin
            h = s.t % HT;
            v = s.t / HT;
            act = (h < HA) && (v < VA);
            hsa = (h >= HA + HF) && (h < HA + HF + HSW);
            vsa = (v >= VA + VF) && (v < VA + VF + VSW);
            n.outv = pack(act, hsa ? HSP : !HSP, vsa ? VSP : !VSP,
                          act ? h : 0, act ? v : 0, s.t == 0, 1);
            n.t = (s.t + 1) % (HT * VT);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ms <= '{h1: 0, h2: 0, rn: 0, streak: 0, t: 0, outv: IDLE};
        else        ms <= mstep(ms, lock);
    end

    task automatic test_reset();
        rst_n = 1'b0; lock = 1'b1; lock2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== IDLE) begin
            errors++; $display("FAIL reset_small got=%h exp=%h", dut_vec, IDLE);
        end
        checks++;
        if (big_vec !== IDLE) begin
            errors++; $display("FAIL reset_1080 got=%h exp=%h", big_vec, IDLE);
        end
    endtask

    task automatic test_lock_qual();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (run !== (i >= 6) || fs !== (i == 7)) begin
                errors++; $display("FAIL lock_qual edge=%0d run=%b fs=%b exp_run=%b exp_fs=%b",
                                   i, run, fs, i >= 6, i == 7);
            end
            checks++;
            if (dut_vec !== ms.outv) begin
                errors++; $display("FAIL lock_qual_model edge=%0d got=%h exp=%h", i, dut_vec, ms.outv);
            end
        end
    endtask

    task automatic test_raster();
        for (int w = 0; w < 2; w++) begin
            int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0;
            for (int c = 0; c < HT * VT; c++) begin
                @(negedge clk);
                n_de += int'(de); n_hs += int'(hs); n_vs += int'(vs); n_fs += int'(fs);
                checks++;
                if (dut_vec !== ms.outv) begin
                    errors++; $display("FAIL raster w=%0d c=%0d got=%h exp=%h", w, c, dut_vec, ms.outv);
                end
            end
            checks++;
            if (n_de != HA * VA || n_hs != HSW * VT || n_vs != VSW * HT || n_fs != 1) begin
                errors++; $display("FAIL raster_counts de=%0d hs=%0d vs=%0d fs=%0d exp=%0d/%0d/%0d/1",
                                   n_de, n_hs, n_vs, n_fs, HA * VA, HSW * VT, VSW * HT);
            end
        end
    endtask

    task automatic test_glitch();
        lock = 1'b0;
        repeat (5) @(negedge clk);
        lock = 1'b1; repeat (3) @(negedge clk);
        lock = 1'b0; @(negedge clk);
        lock = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (run !== (i >= 6)) begin
                errors++; $display("FAIL glitch edge=%0d run=%b exp=%b", i, run, i >= 6);
            end
            checks++;
            if (dut_vec !== ms.outv) begin
                errors++; $display("FAIL glitch_model edge=%0d got=%h exp=%h", i, dut_vec, ms.outv);
            end
        end
    endtask

    task automatic test_drop_relock();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ms.rn && ms.t == 2 * HT + 5) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL drop_wait timeout got=0 exp=1");
        end
        lock = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (de !== 1'b0 || hs !== !HSP || vs !== !VSP || run !== 1'b0) begin
            errors++; $display("FAIL drop_idle de=%b hs=%b vs=%b run=%b exp=0/%b/%b/0", de, hs, vs, run, !HSP, !VSP);
        end
        repeat (2) @(negedge clk);
        lock = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (fs !== (i == 7) || (i == 7 && (x !== 12'd0 || y !== 11'd0 || de !== 1'b1))) begin
                errors++; $display("FAIL relock edge=%0d fs=%b de=%b x=%0d y=%0d exp_fs=%b", i, fs, de, x, y, i == 7);
            end
            checks++;
            if (dut_vec !== ms.outv) begin
                errors++; $display("FAIL relock_model edge=%0d got=%h exp=%h", i, dut_vec, ms.outv);
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ms.outv[27] && ms.outv[24:13] == 12'd3) found = 1'b1;
        end
        checks++;
        if (!found || de !== 1'b1) begin
            errors++; $display("FAIL areset_wait found=%b de=%b exp=1/1", found, de);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== IDLE) begin
            errors++; $display("FAIL areset got=%h exp=%h", dut_vec, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== ms.outv) begin
                errors++; $display("FAIL areset_model edge=%0d got=%h exp=%h", i, dut_vec, ms.outv);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            lock = ($urandom_range(0, 40) != 0);
            if ((c % 300) > 290) lock = $urandom_range(0, 1);
            @(negedge clk);
            checks++;
            if (dut_vec !== ms.outv) begin
                errors++; $display("FAIL random c=%0d lock=%b got=%h exp=%h", c, lock, dut_vec, ms.outv);
            end
        end
        lock = 1'b1;
    endtask

    task automatic test_1080p();
        int cyc = 0;
        bit found = 1'b0;
        lock2 = 1'b1;
        while (!found && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            if (fs2) found = 1'b1;
        end
        // 2 sync edges + 1024 qualify edges, then one edge of output latency.
        checks++;
        if (!found || cyc != 1027) begin
            errors++; $display("FAIL big_fs_latency cyc=%0d exp=1027", cyc);
        end
        for (int off = 0; off < 3 * 2200; off++) begin
            int h = off % 2200, l = off / 2200;
            bit a = (h < 1920);
            logic [27:0] e = pack(a, (h >= 2008) && (h < 2052), 1'b0,
                                  a ? h : 0, a ? l : 0, off == 0, 1'b1);
            if (off != 0) @(negedge clk);
            checks++;
            if (big_vec !== e) begin
                errors++; $display("FAIL big_line off=%0d got=%h exp=%h", off, big_vec, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_qual();
        test_raster();
        test_glitch();
        test_drop_relock();
        test_async_reset();
        test_random();
        test_1080p();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
